serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 5 +
 rtl/serial_adder_ctrl_fa_decoder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 70 +++++++
 tb/tb_serial_adder_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and default operand width
package serial_adder_pkg;
   localparam int DEFAULT_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_adder_ctrl_fa_decoder.sv
// fa_decoder: full-adder cell built from a 3-to-8 decoder and two OR gates
module fa_decoder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic S,
   output logic C
);
   logic [7:0] d;
   assign d = 8'd1 << {x, y, z};
   assign S = d[1] | d[2] | d[4] | d[7];
   assign C = d[3] | d[5] | d[6] | d[7];
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one bit per cycle, LSB first
// SERIAL_ADDER_SUB_EN adds a sub input that turns the operation into a-b
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH) + 1;
   state_t state, nxt;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [CW-1:0] cnt;
   logic carry, s_bit, c_bit, last, sub_en;
`ifdef SERIAL_ADDER_SUB_EN
   assign sub_en = sub;
`else
   assign sub_en = 1'b0;
`endif
   assign last = cnt == CW'(WIDTH - 1);
   assign busy = state == SHIFT;
   assign done = state == DONE;
   fa_decoder u_fa (
      .x (a_sr[0]),
      .y (b_sr[0]),
      .z (carry),
      .S (s_bit),
      .C (c_bit)
   );
   always_comb
      nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
            state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
   always_ff @(posedge clk)
      state <= rst ? IDLE : nxt;
   // two's-complement subtract: invert b and inject a carry of one
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (state == IDLE && start) begin
         a_sr  <= a;
         b_sr  <= b ^ {WIDTH{sub_en}};
         carry <= cin | sub_en;
         cnt   <= '0;
      end else if (state == SHIFT) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         sum   <= {s_bit, sum[WIDTH-1:1]};
         carry <= c_bit;
         cnt   <= cnt + 1'b1;
         if (last) cout <= c_bit;
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the serial adder at WIDTH=8
module tb_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
   logic sub = 1'b0;
`endif
   logic busy, done, cout;
   logic [7:0] sum;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // Starts an operation at a negedge; returns negedges until done and busy count
   task automatic go(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                     output int n, output int nb);
      a = ia; b = ib; cin = ic; start = 1'b1; n = 0; nb = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         start = 1'b0;
         n++;
         nb += int'(busy);
         if (done) break;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, sum, cout} !== 11'd0) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int n, nb;
      go(8'h5A, 8'h3C, 1'b0, n, nb);
      total++;
      if (n !== 9) begin bad++; $display("FAIL basic_latency got %0d want 9", n); end
      total++;
      if ({cout, sum} !== 9'h096) begin bad++; $display("FAIL basic_result got cout=%b sum=%h want 0/96", cout, sum); end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0/0", done, busy); end
   endtask

   task automatic test_carry_busy;
      int n, nb;
      go(8'hFF, 8'h01, 1'b0, n, nb);
      total++;
      if ({cout, sum} !== 9'h100) begin bad++; $display("FAIL carry_result got cout=%b sum=%h want 1/00", cout, sum); end
      total++;
      if (nb !== 8) begin bad++; $display("FAIL carry_busy_cycles got %0d want 8", nb); end
      @(negedge clk);
   endtask

   task automatic test_add_table;
      logic [7:0] ta [4] = '{8'h80, 8'h00, 8'h12, 8'hA5};
      logic [7:0] tb [4] = '{8'h80, 8'h00, 8'h34, 8'h5A};
      logic       tc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [8:0] tr [4] = '{9'h100, 9'h001, 9'h047, 9'h100};
      int n, nb;
      for (int i = 0; i < 4; i++) begin
         go(ta[i], tb[i], tc[i], n, nb);
         total++;
         if ({cout, sum} !== tr[i] || n !== 9) begin
            bad++;
            $display("FAIL add_table[%0d] got cout/sum=%h lat=%0d want %h lat=9", i, {cout, sum}, n, tr[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      int n = 0, n2 = 0;
      a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         n++;
         if (done) break;
      end
      total++;
      if (n !== 9 || {cout, sum} !== 9'h1FF) begin
         bad++;
         $display("FAIL b2b_first got lat=%0d cout/sum=%h want 9/1ff", n, {cout, sum});
      end
      a = 8'h01; b = 8'h02; cin = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || {cout, sum} !== 9'h1FF) begin
         bad++;
         $display("FAIL b2b_idle_gap got busy=%b done=%b cout/sum=%h want 0/0/1ff", busy, done, {cout, sum});
      end
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart got busy=%b want 1", busy); end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         n2++;
         if (done) break;
      end
      total++;
      if (n2 !== 8 || {cout, sum} !== 9'h003) begin
         bad++;
         $display("FAIL b2b_second got lat=%0d cout/sum=%h want 8/003", n2, {cout, sum});
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_start;
      int n = 0;
      a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         n++;
         start = (n == 3);
         if (n == 3) begin a = 8'hAA; b = 8'hAA; cin = 1'b0; end
         if (done) break;
      end
      total++;
      if (n !== 9 || {cout, sum} !== 9'h047) begin
         bad++;
         $display("FAIL ignore_start got lat=%0d cout/sum=%h want 9/047", n, {cout, sum});
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_queue got busy=%b want 0", busy); end
   endtask

   task automatic test_abort;
      int nd = 0, nb2 = 0, n, nb;
      a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy got %b want 1", busy); end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, done, sum, cout} !== 11'd0) begin
         bad++;
         $display("FAIL abort_outputs got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
      end
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         nd += int'(done);
         nb2 += int'(busy);
      end
      total++;
      if (nd !== 0 || nb2 !== 0) begin bad++; $display("FAIL abort_no_done got done=%0d busy=%0d want 0/0", nd, nb2); end
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_priority got busy=%b want 0", busy); end
      go(8'h0F, 8'h01, 1'b0, n, nb);
      total++;
      if (n !== 9 || {cout, sum} !== 9'h010) begin
         bad++;
         $display("FAIL post_rst_op got lat=%0d cout/sum=%h want 9/010", n, {cout, sum});
      end
      @(negedge clk);
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub;
      int n, nb;
      sub = 1'b1;
      go(8'h10, 8'h01, 1'b0, n, nb);
      total++;
      if ({cout, sum} !== 9'h10F) begin bad++; $display("FAIL sub_no_borrow got cout/sum=%h want 10f", {cout, sum}); end
      @(negedge clk);
      go(8'h01, 8'h02, 1'b0, n, nb);
      total++;
      if ({cout, sum} !== 9'h0FF) begin bad++; $display("FAIL sub_borrow got cout/sum=%h want 0ff", {cout, sum}); end
      sub = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_carry_busy;
      test_add_table;
      test_back_to_back;
      test_ignore_start;
      test_abort;
`ifdef SERIAL_ADDER_SUB_EN
      test_sub;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
